// File: rtl/tdc_pkg.sv
// Shared types and defaults for the time-to-digital converter.
package tdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } tdc_state_e;

  localparam int TDC_WIDTH_DEF       = 8;
  localparam int TDC_SYNC_STAGES_DEF = 2;
  localparam int TDC_TIMEOUT_DEF     = 255;

  // Bits needed to hold 0..limit; a disabled (zero) limit still gets one bit.
  function automatic int cnt_bits(input int limit);
    if (limit > 0) begin
      return $clog2(limit + 1);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/tdc_if.sv
// Result channel of the TDC: measured code plus flags under valid/ready.
interface tdc_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] tdc_out;
  logic             out_valid;
  logic             out_ready;
  logic             overflow;
  logic             timeout;

  modport master (
    output tdc_out,
    output out_valid,
    output overflow,
    output timeout,
    input  out_ready
  );

  modport slave (
    input  tdc_out,
    input  out_valid,
    input  overflow,
    input  timeout,
    output out_ready
  );
endinterface

// File: rtl/tdc_sync.sv
// Input synchronizer for tdc_in plus one-cycle history for rising-edge detection.
module tdc_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tdc_in,
  output logic s,
  output logic rise
);
  logic s_prev_q;
  logic s_prev_d;

  if (SYNC_STAGES == 0) begin : g_direct
    assign s = tdc_in;
  end else begin : g_chain
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // Shift the pin value one stage per cycle.
    always_comb begin
      sync_d[0] = tdc_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_d[i] = sync_q[i-1];
      end
    end

    // Synchronizer flops.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q <= {SYNC_STAGES{1'b0}};
      end else begin
        sync_q <= sync_d;
      end
    end

    assign s = sync_q[SYNC_STAGES-1];
  end

  assign s_prev_d = s;
  assign rise     = s & ~s_prev_q;

  // History flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_prev_q <= 1'b0;
    end else begin
      s_prev_q <= s_prev_d;
    end
  end
endmodule

// File: rtl/tdc.sv
// Time-to-digital converter: after trig, counts cycles the synchronized pulse
// stays high and offers the count with overflow/timeout flags on res.
module tdc
  import tdc_pkg::*;
#(
  parameter int WIDTH       = TDC_WIDTH_DEF,
  parameter int SYNC_STAGES = TDC_SYNC_STAGES_DEF,
  parameter int TIMEOUT     = TDC_TIMEOUT_DEF
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  tdc_in,
  input  logic  trig,
  output logic  busy,
  tdc_if.master res
);
  localparam int               TW      = cnt_bits(TIMEOUT);
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [TW-1:0]    TO_LAST = TW'(TIMEOUT - 1);

  logic s;
  logic rise;

  tdc_state_e       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [WIDTH-1:0] code_q, code_d;
  logic             ovf_q, ovf_d;
  logic             tmo_q, tmo_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  tdc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .tdc_in (tdc_in),
    .s      (s),
    .rise   (rise)
  );

  // Next-state and next-output logic of the measurement FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    code_d  = code_q;
    ovf_d   = ovf_q;
    tmo_d   = tmo_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d   = {WIDTH{1'b0}};
        tcnt_d  = {TW{1'b0}};
        code_d  = {WIDTH{1'b0}};
        ovf_d   = 1'b0;
        tmo_d   = 1'b0;
        valid_d = 1'b0;
        if (trig) begin
          state_d = ST_ARMED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (trig) begin
          cnt_d  = {WIDTH{1'b0}};
          tcnt_d = {TW{1'b0}};
        end else if (rise) begin
          state_d = ST_MEASURE;
          cnt_d   = WIDTH'(1);
        end else if ((TIMEOUT != 0) && (tcnt_q == TO_LAST)) begin
          state_d = ST_DONE;
          code_d  = {WIDTH{1'b0}};
          tmo_d   = 1'b1;
          valid_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      ST_MEASURE: begin
        if (trig) begin
          state_d = ST_ARMED;
          cnt_d   = {WIDTH{1'b0}};
          tcnt_d  = {TW{1'b0}};
        end else if (s) begin
          // Saturated and still high: report overflow without waiting for the fall.
          if (cnt_q == CNT_MAX) begin
            state_d = ST_DONE;
            code_d  = CNT_MAX;
            ovf_d   = 1'b1;
            valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end else begin
          state_d = ST_DONE;
          code_d  = cnt_q;
          valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (res.out_ready) begin
          cnt_d   = {WIDTH{1'b0}};
          tcnt_d  = {TW{1'b0}};
          code_d  = {WIDTH{1'b0}};
          ovf_d   = 1'b0;
          tmo_d   = 1'b0;
          valid_d = 1'b0;
          if (trig) begin
            state_d = ST_ARMED;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {WIDTH{1'b0}};
      tcnt_q  <= {TW{1'b0}};
      code_q  <= {WIDTH{1'b0}};
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      code_q  <= code_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign res.tdc_out   = code_q;
  assign res.out_valid = valid_q;
  assign res.overflow  = ovf_q;
  assign res.timeout   = tmo_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_tdc.sv
// Scoreboard bench: two TDCs (SYNC 0 / TIMEOUT 20 and SYNC 2 / TIMEOUT 255) share stimulus.
module tb_tdc;
  localparam int W      = 8;
  localparam int SYNC_A = 0;
  localparam int TO_A   = 20;
  localparam int SYNC_B = 2;
  localparam int TO_B   = 255;

  typedef struct {
    int code;
    int ovf;
    int tmo;
    int cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       tdc_in;
  logic       trig;
  logic       busy_a;
  logic       busy_b;
  logic [1:0] rdy;

  tdc_if #(.WIDTH(W)) if_a ();
  tdc_if #(.WIDTH(W)) if_b ();

  assign if_a.out_ready = rdy[0];
  assign if_b.out_ready = rdy[1];

  tdc #(.WIDTH(W), .SYNC_STAGES(SYNC_A), .TIMEOUT(TO_A)) dut_a (
    .clk(clk), .rst(rst), .tdc_in(tdc_in), .trig(trig), .busy(busy_a), .res(if_a)
  );
  tdc #(.WIDTH(W), .SYNC_STAGES(SYNC_B), .TIMEOUT(TO_B)) dut_b (
    .clk(clk), .rst(rst), .tdc_in(tdc_in), .trig(trig), .busy(busy_b), .res(if_b)
  );

  always #5 clk = ~clk;

  int ec = 0;
  always @(posedge clk) ec <= ec + 1;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks   = 0;
  int   failures = 0;
  int   mode     = 0;   // 0 random ready, 1 ready held low, 2 ready held high

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  // Expected result of an armed pulse of n pin cycles whose first high sample is edge a+1.
  function automatic exp_t pulse_exp(int n, int a, int sync);
    exp_t e;
    e.tmo = 0;
    if (n > (1 << W) - 1) begin
      e.code = (1 << W) - 1;
      e.ovf  = 1;
      e.cyc  = a + sync + (1 << W);
    end else begin
      e.code = n;
      e.ovf  = 0;
      e.cyc  = a + n + 1 + sync;
    end
    return e;
  endfunction

  function automatic void push_pulse(int n, int a);
    q_a.push_back(pulse_exp(n, a, SYNC_A));
    q_b.push_back(pulse_exp(n, a, SYNC_B));
  endfunction

  function automatic void push_timeout(int d);
    exp_t e;
    e.code = 0; e.ovf = 0; e.tmo = 1;
    e.cyc = d + 1 + TO_A;
    q_a.push_back(e);
    e.cyc = d + 1 + TO_B;
    q_b.push_back(e);
  endfunction

  task automatic do_trig(output int d);
    @(negedge clk);
    trig = 1'b1;
    d = ec;
    @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic idle_cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(int n, bit expect_it);
    int a;
    @(negedge clk);
    tdc_in = 1'b1;
    a = ec;
    if (expect_it) push_pulse(n, a);
    repeat (n) @(negedge clk);
    tdc_in = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int i = 0;
    while (i < 3000 && (busy_a || busy_b || q_a.size() != 0 || q_b.size() != 0)) begin
      @(negedge clk);
      i++;
    end
    if (i >= 3000) begin
      checks++; failures++;
      $display("FAIL %s_idle actual=busy_a:%0b,busy_b:%0b,pending:%0d expected=idle", name,
               busy_a, busy_b, q_a.size() + q_b.size());
    end
  endtask

  task automatic wait_valid(string name);
    int i = 0;
    while (i < 3000 && !(if_a.out_valid && if_b.out_valid)) begin
      @(negedge clk);
      i++;
    end
    if (i >= 3000) begin
      checks++; failures++;
      $display("FAIL %s_valid actual=%0b%0b expected=11", name, if_a.out_valid, if_b.out_valid);
    end
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_a_code"},  int'(if_a.tdc_out),   0);
    chk({tag, "_a_valid"}, int'(if_a.out_valid), 0);
    chk({tag, "_a_ovf"},   int'(if_a.overflow),  0);
    chk({tag, "_a_tmo"},   int'(if_a.timeout),   0);
    chk({tag, "_a_busy"},  int'(busy_a),         0);
    chk({tag, "_b_code"},  int'(if_b.tdc_out),   0);
    chk({tag, "_b_valid"}, int'(if_b.out_valid), 0);
    chk({tag, "_b_ovf"},   int'(if_b.overflow),  0);
    chk({tag, "_b_tmo"},   int'(if_b.timeout),   0);
    chk({tag, "_b_busy"},  int'(busy_b),         0);
  endtask

  // Monitor/consumer: pops expectations on each new result, checks hold and drop.
  initial begin
    bit    seen [2];
    bit    acked[2];
    bit    bogus[2];
    exp_t  cur  [2];
    exp_t  e;
    int    v, c, o, t, qn;
    bit    r;
    string tag;
    rdy = 2'b00;
    forever begin
      @(negedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        tag = (k == 0) ? "a" : "b";
        v = (k == 0) ? int'(if_a.out_valid) : int'(if_b.out_valid);
        c = (k == 0) ? int'(if_a.tdc_out)   : int'(if_b.tdc_out);
        o = (k == 0) ? int'(if_a.overflow)  : int'(if_b.overflow);
        t = (k == 0) ? int'(if_a.timeout)   : int'(if_b.timeout);
        if (rst) begin
          seen[k] = 1'b0; acked[k] = 1'b0; bogus[k] = 1'b0;
        end else begin
          if (acked[k]) begin
            chk({tag, "_valid_drop"}, v, 0);
            acked[k] = 1'b0; seen[k] = 1'b0; bogus[k] = 1'b0;
          end
          if (v != 0 && !seen[k]) begin
            seen[k] = 1'b1;
            qn = (k == 0) ? q_a.size() : q_b.size();
            if (qn == 0) begin
              checks++; failures++; bogus[k] = 1'b1;
              $display("FAIL %s_unexpected_valid actual=code:%0d expected=no_result", tag, c);
            end else begin
              e = (k == 0) ? q_a.pop_front() : q_b.pop_front();
              cur[k] = e;
              chk({tag, "_code"}, c, e.code);
              chk({tag, "_overflow"}, o, e.ovf);
              chk({tag, "_timeout"}, t, e.tmo);
              chk({tag, "_latency_cycle"}, ec, e.cyc);
            end
          end else if (v != 0 && !bogus[k]) begin
            chk({tag, "_hold_code"}, c, cur[k].code);
            chk({tag, "_hold_overflow"}, o, cur[k].ovf);
            chk({tag, "_hold_timeout"}, t, cur[k].tmo);
          end else if (v == 0) begin
            seen[k] = 1'b0; bogus[k] = 1'b0;
          end
        end
        case (mode)
          1:       r = 1'b0;
          2:       r = 1'b1;
          default: r = ($urandom_range(0, 2) == 0);
        endcase
        if (v != 0 && seen[k] && r && !rst) acked[k] = 1'b1;
        rdy[k] = r;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d;
    rst = 1'b1; tdc_in = 1'b0; trig = 1'b0;
    idle_cycles(3);
    check_zero("reset");
    rst = 1'b0;
    idle_cycles(2);

    // 5-cycle pulse, result held under backpressure, then released.
    mode = 1;
    do_trig(d); idle_cycles(2); pulse(5, 1'b1);
    wait_valid("basic");
    idle_cycles(3);
    mode = 2;
    idle_cycles(2);
    chk("basic_a_busy", int'(busy_a), 0);
    chk("basic_b_busy", int'(busy_b), 0);
    chk("basic_a_valid", int'(if_a.out_valid), 0);
    chk("basic_b_valid", int'(if_b.out_valid), 0);
    mode = 0;

    do_trig(d); pulse(37, 1'b1); wait_idle("loop37");

    do_trig(d); push_timeout(d); wait_idle("timeout");

    do_trig(d); pulse(300, 1'b1); wait_idle("ovf300");
    do_trig(d); pulse(255, 1'b1); wait_idle("n255");
    do_trig(d); pulse(256, 1'b1); wait_idle("n256");

    // Input already high when armed: only the later pulse counts.
    tdc_in = 1'b1; idle_cycles(2);
    do_trig(d); idle_cycles(2);
    tdc_in = 1'b0; idle_cycles(2);
    pulse(4, 1'b1); wait_idle("prehigh");

    // Re-trigger mid-measure aborts; only the fresh pulse reports.
    do_trig(d); idle_cycles(1);
    @(negedge clk); tdc_in = 1'b1;
    repeat (6) @(negedge clk);
    trig = 1'b1;
    @(negedge clk); trig = 1'b0;
    repeat (3) @(negedge clk);
    tdc_in = 1'b0;
    idle_cycles(2);
    pulse(7, 1'b1); wait_idle("abort");

    // Accept and re-arm in the same cycle.
    mode = 1;
    do_trig(d); pulse(3, 1'b1);
    wait_valid("rearm");
    @(negedge clk); trig = 1'b1; mode = 2;
    @(negedge clk); trig = 1'b0; mode = 1;
    chk("rearm_a_busy", int'(busy_a), 1);
    chk("rearm_b_busy", int'(busy_b), 1);
    chk("rearm_a_valid", int'(if_a.out_valid), 0);
    chk("rearm_b_valid", int'(if_b.out_valid), 0);
    mode = 0;
    pulse(2, 1'b1); wait_idle("rearm2");

    for (int it = 0; it < 30; it++) begin
      int kind;
      int n;
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        do_trig(d); push_timeout(d); wait_idle("rand_tmo");
      end else begin
        n = (kind == 1) ? $urandom_range(250, 262) : $urandom_range(1, 40);
        do_trig(d); idle_cycles($urandom_range(0, 6));
        pulse(n, 1'b1); idle_cycles($urandom_range(0, 3));
        wait_idle("rand");
      end
    end

    // Reset mid-measure, then a pulse without trig must produce nothing.
    do_trig(d); idle_cycles(1);
    @(negedge clk); tdc_in = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    tdc_in = 1'b0;
    idle_cycles(3);
    pulse(6, 1'b0);
    idle_cycles(30);
    chk("norearm_a_busy", int'(busy_a), 0);
    chk("norearm_b_busy", int'(busy_b), 0);

    chk("pending_a", q_a.size(), 0);
    chk("pending_b", q_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
